// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// register map, scan state encoding and control bit positions.
package seg_pkg;

  localparam logic [1:0] REG_DATA_HI = 2'd0;
  localparam logic [1:0] REG_DATA_LO = 2'd1;
  localparam logic [1:0] REG_MASK    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int unsigned EN_BIT = 0;

  // Digit index to active-high one-hot digit enable.
  function automatic logic [3:0] digit_onehot(input logic [1:0] i);
    return 4'(4'b0001 << i);
  endfunction

endpackage

// File: rtl/segled.sv
// Hex nibble to 7-segment decoder, active-low outputs, z[6:0] = g..a.
module segled (
  input  logic [3:0] x,
  output logic [6:0] z
);

  always_comb begin
    z = 7'h7F;
    case (x)
      4'h0: z = 7'h40;
      4'h1: z = 7'h79;
      4'h2: z = 7'h24;
      4'h3: z = 7'h30;
      4'h4: z = 7'h19;
      4'h5: z = 7'h12;
      4'h6: z = 7'h02;
      4'h7: z = 7'h78;
      4'h8: z = 7'h00;
      4'h9: z = 7'h10;
      4'hA: z = 7'h08;
      4'hB: z = 7'h03;
      4'hC: z = 7'h46;
      4'hD: z = 7'h21;
      4'hE: z = 7'h06;
      4'hF: z = 7'h0E;
      default: z = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// CPU-bus peripheral scanning a 4-digit multiplexed 7-segment display with
// a programmable per-digit dwell followed by an all-dark anti-ghosting gap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIV       = 2080,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       read,
  input  logic [1:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] seg,
  output logic [3:0] dig
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [7:0]       data_hi;
  logic [7:0]       data_lo;
  logic [7:0]       mask;
  logic             en;
  logic [7:0]       rd_data;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [1:0]       idx;
  logic [1:0]       idx_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             frame;
  logic             frame_d;
  logic [7:0]       seg_d;
  logic [3:0]       dig_d;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [3:0]       dp;
  logic [3:0]       blank;

  assign dp    = mask[3:0];
  assign blank = mask[7:4];

  // Register file writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_hi <= '0;
      data_lo <= '0;
      mask    <= '0;
      en      <= 1'b0;
    end else if (cs && !read) begin
      case (address)
        REG_DATA_HI: data_hi <= din;
        REG_DATA_LO: data_lo <= din;
        REG_MASK:    mask    <= din;
        REG_CTRL:    en      <= din[EN_BIT];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = data_hi;
    case (address)
      REG_DATA_HI: rd_data = data_hi;
      REG_DATA_LO: rd_data = data_lo;
      REG_MASK:    rd_data = mask;
      REG_CTRL:    rd_data = {frame, 3'b000, idx, 1'b0, en};
      default:     rd_data = data_hi;
    endcase
  end

  // Read data is held between requests, matching SRAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (cs && read) begin
      dout <= rd_data;
    end
  end

  // Scan sequencing: OFF -> SHOW (dwell) -> GAP (dark) -> SHOW next digit
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    frame_d = frame;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_SHOW: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(BLANK_CYC - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            idx_d   = idx + 2'd1;
            if (idx == 2'd3) begin
              frame_d = ~frame;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decode the digit that will be lit after this edge so dig and seg switch together
  always_comb begin
    nibble = data_lo[3:0];
    case (idx_d)
      2'd0:    nibble = data_hi[7:4];
      2'd1:    nibble = data_hi[3:0];
      2'd2:    nibble = data_lo[7:4];
      default: nibble = data_lo[3:0];
    endcase
  end

  segled u_segled (
    .x (nibble),
    .z (glyph)
  );

  always_comb begin
    dig_d = '0;
    seg_d = 8'hFF;
    if (state_d == ST_SHOW) begin
      dig_d = digit_onehot(idx_d);
      if (!blank[idx_d]) begin
        seg_d = {~dp[idx_d], glyph};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_OFF;
      idx   <= '0;
      cnt   <= '0;
      frame <= 1'b0;
      seg   <= 8'hFF;
      dig   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      frame <= frame_d;
      seg   <= seg_d;
      dig   <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a timeline model of the display scan
// predicts seg/dig/dout per clock; a monitor pops and compares each cycle.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV       = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          SLOT      = DIV + BLANK_CYC;
  localparam int          FRAME     = 4 * SLOT;

  // Active-high g..a patterns for hex digits 0..F
  localparam logic [6:0] GLYPH_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0;
  logic       read = 1'b0;
  logic [1:0] address = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [7:0] seg;
  logic [3:0] dig;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .read    (read),
    .address (address),
    .din     (din),
    .dout    (dout),
    .seg     (seg),
    .dig     (dig)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic [7:0] dout;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: registers plus time elapsed since the scan last started
  logic [7:0] m_hi, m_lo, m_mask, m_dout;
  bit         m_en, m_run, m_frame;
  int         m_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_mask = '0; m_dout = '0;
    m_en = 1'b0; m_run = 1'b0; m_frame = 1'b0; m_t = 0;
  endtask

  function automatic int cur_digit();
    return m_run ? (m_t / SLOT) % 4 : 0;
  endfunction

  function automatic logic [3:0] nib(input int d);
    case (d)
      0:       return m_hi[7:4];
      1:       return m_hi[3:0];
      2:       return m_lo[7:4];
      default: return m_lo[3:0];
    endcase
  endfunction

  // Drive one bus cycle and predict the outputs after the following posedge
  task automatic apply(input bit c, input bit r, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    int   di;
    cs = c; read = r; address = a; din = d;
    e.dout = m_dout;
    if (c && r) begin
      case (a)
        2'd0:    e.dout = m_hi;
        2'd1:    e.dout = m_lo;
        2'd2:    e.dout = m_mask;
        default: e.dout = {m_frame, 3'b000, 2'(cur_digit()), 1'b0, m_en};
      endcase
    end
    if (m_en) begin
      if (m_run) m_t++;
      else begin
        m_run = 1'b1;
        m_t   = 0;
      end
      if (m_t > 0 && (m_t % FRAME) == 0) m_frame = ~m_frame;
    end else begin
      m_run = 1'b0;
      m_t   = 0;
    end
    e.seg = 8'hFF;
    e.dig = 4'b0000;
    if (m_run && (m_t % SLOT) < DIV) begin
      di    = (m_t / SLOT) % 4;
      e.dig = 4'(1 << di);
      if (!m_mask[4 + di]) e.seg = {~m_mask[di], ~GLYPH_ON[nib(di)]};
    end
    if (c && !r) begin
      case (a)
        2'd0:    m_hi   = d;
        2'd1:    m_lo   = d;
        2'd2:    m_mask = d;
        default: m_en   = d[0];
      endcase
    end
    m_dout = e.dout;
    expq.push_back(e);
  endtask

  task automatic step(input bit c, input bit r, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    apply(c, r, a, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic idle_rand(input int n);
    repeat (n) begin
      if ($urandom_range(1, 0) == 1) step(1'b1, 1'b1, 2'($urandom), 8'($urandom));
      else step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
    end
  endtask

  // Advance until the model shows digit d at dwell position s
  task automatic wait_digit(input int d, input int s);
    int n = 0;
    while (!(m_run && (m_t / SLOT) % 4 == d && (m_t % SLOT) == s) && n < 200) begin
      step(1'b0, 1'b0, 2'd0, 8'h00);
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_digit timeout digit=%0d pos=%0d", d, s);
    end
  endtask

  // Assert reset between clock edges; outputs must go dark without an edge
  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_seg", seg, 8'hFF);
    check("rst_async_dig", dig, 4'h0);
    check("rst_async_dout", dout, 8'h00);
    repeat (ncyc) begin
      @(negedge clk);
      cs = 1'($urandom); read = 1'($urandom); address = 2'($urandom); din = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold_seg", seg, 8'hFF);
      check("rst_hold_dig", dig, 4'h0);
      check("rst_hold_dout", dout, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  // Monitor: compare every predicted cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        check("seg", seg, mon_e.seg);
        check("dig", dig, mon_e.dig);
        check("dout", dout, mon_e.dout);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(5);
    step(1'b1, 1'b1, 2'd3, 8'h00);
    step(1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b0, 1'b0, 2'd0, 8'h00);

    wr(2'd0, 8'h12);
    wr(2'd1, 8'h34);
    wr(2'd3, 8'h01);
    idle_rand(2 * FRAME + 10);

    wr(2'd2, 8'h21);
    idle_rand(FRAME + 5);

    wait_digit(2, 3);
    wr(2'd3, 8'h00);
    idle_rand(5);
    wr(2'd3, 8'hFF);
    idle_rand(FRAME / 2);

    wait_digit(2, 2);
    wr(2'd1, 8'hAB);
    idle_rand(SLOT * 2);

    wait_digit(1, 4);
    do_reset(3);
    for (int a = 0; a < 4; a++) step(1'b1, 1'b1, 2'(a), 8'h00);
    step(1'b0, 1'b0, 2'd0, 8'h00);

    wr(2'd0, 8'($urandom));
    wr(2'd1, 8'($urandom));
    wr(2'd3, 8'h01);
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = int'($urandom_range(99, 0));
      if (p < 8) wr(2'($urandom_range(1, 0)), 8'($urandom));
      else if (p < 11) wr(2'd2, 8'($urandom));
      else if (p < 12) wr(2'd3, {7'($urandom), 1'($urandom_range(3, 0) != 0)});
      else if (p < 14) wr(2'd3, 8'h01);
      else if (p < 45) step(1'b1, 1'b1, 2'($urandom), 8'($urandom));
      else step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
    end

    repeat (3) step(1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
